// File: rtl/alu_pkg.sv
// Shared types and default sizing for the ALU command engine.
package alu_pkg;

  localparam int ALU_WIDTH = 6;
  localparam int ALU_DEPTH = 16;
  localparam int ALU_OPW   = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SRA = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with registered read port; storage is deliberately left unreset.
module cmd_fifo #(
  parameter int WIDTH_D = 15,
  parameter int DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH_D-1:0]         wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH_D-1:0]         rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH_D-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH_D-1:0] rd_data_q;
  logic               full, empty;
  logic               do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q    <= rptr_q + AW'(1);
        rd_data_q <= mem_q[rptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full;
  assign empty_o   = empty;
  assign count_o   = count_q;

endmodule

// File: rtl/alu_engine.sv
// Queued signed ALU: commands are pushed into cmd_fifo and issued one at a time
// by a three-state sequencer (IDLE -> READ -> EXEC), by step pulse or in run mode.
module alu_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_DEPTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid_i,
  input  logic [OPW+2*WIDTH-1:0]     wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       step_i,
  input  logic                       run_mode_i,
  output logic [WIDTH-1:0]           result_o,
  output logic                       result_valid_o,
  output logic                       overflow_o,
  output logic                       neg_result_o,
  output logic                       zero_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [7:0]                 ovf_count_o
);

  localparam int DW = OPW + 2*WIDTH;

  state_t             state_q, state_d;
  logic               pop;
  logic [DW-1:0]      fifo_rd_data;
  logic               fifo_full, fifo_empty;

  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q;

  logic [WIDTH:0]     add_ext, sub_ext;
  logic [2*WIDTH-1:0] shl_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;

  logic [WIDTH-1:0]   result_q;
  logic               valid_q, ovf_q, neg_q, zero_q;
  logic [7:0]         ovf_cnt_q;

  cmd_fifo #(
    .WIDTH_D (DW),
    .DEPTH   (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (wr_valid_i),
    .wr_data_i (wr_data_i),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (count_o)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (step_i || run_mode_i)) begin
          pop     = 1'b1;
          state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        if (run_mode_i && !fifo_empty) begin
          pop     = 1'b1;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state_q == READ) begin
      op_q <= op_t'(fifo_rd_data[DW-1 -: OPW]);
      a_q  <= fifo_rd_data[2*WIDTH-1:WIDTH];
      b_q  <= fifo_rd_data[WIDTH-1:0];
    end
  end

  // One guard bit on add/sub: overflow shows up as guard != result sign.
  assign add_ext = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
  assign sub_ext = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
  assign shl_ext = {{WIDTH{1'b0}}, a_q} << b_q[2:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_ovf = (shl_ext[WIDTH-1] != a_q[WIDTH-1]) ||
                  (!a_q[WIDTH-1] && (|shl_ext[2*WIDTH-1:WIDTH]));
      end
      OP_SRA: alu_res = $signed(a_q) >>> b_q[2:0];
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // ovf_count moves on the same edge as the result so it is current during the valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b1;
      ovf_cnt_q <= '0;
    end else if (state_q == EXEC) begin
      result_q <= alu_res;
      valid_q  <= 1'b1;
      ovf_q    <= alu_ovf;
      neg_q    <= alu_res[WIDTH-1];
      zero_q   <= (alu_res == '0);
      if (alu_ovf && (ovf_cnt_q != 8'hFF)) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign wr_ready_o     = !fifo_full;
  assign full_o         = fifo_full;
  assign empty_o        = fifo_empty;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign overflow_o     = ovf_q;
  assign neg_result_o   = neg_q;
  assign zero_o         = zero_q;
  assign ovf_count_o    = ovf_cnt_q;

endmodule

// File: doc/alu_engine.md
ALU_ENGINE -- requirements
Module: alu_engine

Interface
REQ-001 Parameter WIDTH, default 6: signed operand/result width, two's complement.
REQ-002 Parameter DEPTH, default 16: command FIFO entries, power of two, at least 2.
REQ-003 Parameter OPW, default 3: opcode width, fixed at 3 in this generation.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-006 wr_valid  in  1  push request for wr_data.
REQ-007 wr_data  in  OPW+2*WIDTH  {op, A, B}; op in MSBs, B in LSBs.
REQ-008 wr_ready  out  1  equals !full; push accepted only when wr_valid && wr_ready.
REQ-009 step  in  1  single-cycle pulse, already synchronised upstream; issues one command.
REQ-010 run_mode  in  1  1 = issue continuously while FIFO non-empty; 0 = step mode.
REQ-011 result  out  WIDTH  last computed result, held until next result.
REQ-012 result_valid  out  1  one-cycle pulse when result updates.
REQ-013 overflow, neg_result, zero  out  1 each  flags for the current result, updated with result.
REQ-014 full, empty  out  1 each  FIFO status.
REQ-015 count  out  $clog2(DEPTH+1)  FIFO occupancy.
REQ-016 ovf_count  out  8  saturating count of results with overflow=1.

Function
REQ-017 FIFO: push on wr_valid && !full; pop only by FSM; push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
REQ-018 Push while full is ignored: no data change, no pointer change.
REQ-019 FSM states IDLE, READ, EXEC.
REQ-020 IDLE -> READ when !empty && (step || run_mode); pop asserted in that cycle.
REQ-021 READ: registered FIFO read data valid; decode into op, A, B; always -> EXEC.
REQ-022 EXEC: result and flags registered; result_valid asserted the following cycle.
REQ-023 EXEC -> READ when run_mode && !empty, with pop in that cycle; otherwise -> IDLE.
REQ-024 Latency: step in cycle t gives result_valid in cycle t+3; run-mode throughput is one result per 2 cycles.
REQ-025 step outside IDLE is ignored, not queued; step with empty=1 is ignored.
REQ-026 run_mode deasserted mid-operation: the current command completes, then the FSM goes to IDLE.
REQ-027 Ops: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by B[2:0], 111 SRA A by B[2:0].
REQ-028 Result is truncated to WIDTH bits.
REQ-029 overflow is set on ADD/SUB when the signed result leaves [-2^(WIDTH-1), 2^(WIDTH-1)-1], and on SHL when the result sign differs from A's sign or set bits are shifted out of a positive A; it is 0 for all other ops.
REQ-030 neg_result = result[WIDTH-1]; zero = (result == 0).
REQ-031 ovf_count increments on each result_valid with overflow=1 and holds at 255.

Reset
REQ-032 On reset=0: state=IDLE, both pointers and count=0, empty=1, full=0, result=0, result_valid=0, overflow=0, neg_result=0, zero=1, ovf_count=0.
REQ-033 Reset mid-operation aborts the in-flight command with no result_valid, and discards FIFO contents.
REQ-034 FIFO storage RAM is not reset.

Structure
REQ-035 Package alu_pkg holds the op_t enum (8 opcodes), the state_t enum, and default WIDTH/DEPTH constants.
REQ-036 FIFO is a sub-module cmd_fifo (parameters WIDTH_D, DEPTH; registered read); the FSM and datapath live in alu_engine.

Verification
REQ-037 Push {ADD,5,3}, pulse step -> 3 cycles later result=8, result_valid for 1 cycle, overflow=0, zero=0.
REQ-038 WIDTH=6, {ADD,31,1} -> result=-32 (6'b100000), overflow=1, neg_result=1, ovf_count=1; {SUB,-32,1} -> result=31, overflow=1.
REQ-039 Push 16 commands -> full=1, wr_ready=0; 17th push ignored; run_mode=1 -> 16 results at 2-cycle spacing, then empty=1, FSM in IDLE.
REQ-040 Simultaneous push and pop at count=8 -> count stays 8; pointers wrap correctly after 40 mixed operations, checked against a scoreboard.
REQ-041 Step pulses in READ/EXEC and with empty=1 -> no extra results; reset=0 asserted in EXEC -> no result_valid, all outputs at reset values.
REQ-042 {SHL,-3,2} -> -12, overflow=0; {SHL,20,1} -> -24, overflow=1; {SRA,-8,2} -> -2; {NOT,0,x} -> -1.
